grid_clb_param: RTL and testbench
=================================

GRID_CLB_PARAM -- requirements
Module: grid_clb_param

Interface
REQ-001 SHALL provide parameter N_IN, default 12: number of tile input pins.
REQ-002 SHALL provide parameter N_BLE, default 4: number of basic logic elements (BLEs) and output pins.
REQ-003 SHALL provide parameter K, default 4: LUT input count per BLE.
REQ-004 SHALL derive SEL_W = clog2(N_IN+N_BLE), BLE_BITS = 2^K + K*SEL_W + 2, and CFG_BITS = N_BLE*BLE_BITS; with defaults these are 4, 34 and 136.
REQ-005 SHALL provide port clk, input, 1 bit: the single clock, used for both configuration shift and user logic.
REQ-006 SHALL provide port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL provide port prog_en, input, 1 bit: 1 selects programming mode, 0 selects run mode.
REQ-008 SHALL provide port ccff_head, input, 1 bit: configuration chain serial input.
REQ-009 SHALL provide port clb_I, input, N_IN bits: tile inputs.
REQ-010 SHALL provide port clb_O, output, N_BLE bits: BLE outputs.
REQ-011 SHALL provide port ccff_tail, output, 1 bit: equals cfg[CFG_BITS-1].
REQ-012 SHALL provide port cfg_done, output, 1 bit: a full bitstream has been loaded and the tile is in run mode.

Function
REQ-013 SHALL hold configuration in register cfg[CFG_BITS-1:0]; on each clk edge with prog_en=1, cfg[0] SHALL take ccff_head and cfg[i] SHALL take cfg[i-1]; cfg SHALL hold when prog_en=0.
REQ-014 SHALL place BLE b in cfg[b*BLE_BITS +: BLE_BITS], with these offsets: [0 +: 2^K] LUT truth table; [2^K + j*SEL_W +: SEL_W] input select j; bit 2^K+K*SEL_W is ff_en; the next bit is ff_init. The bitstream SHALL be sent MSB first.
REQ-015 For each BLE input j, a select value s < N_IN SHALL pick clb_I[s]; N_IN <= s < N_IN+N_BLE SHALL pick clb_O[s-N_IN] (feedback); any larger s SHALL pick clb_I[0].
REQ-016 LUT output SHALL equal truth_table[{in[K-1],...,in[0]}].
REQ-017 With ff_en=0, the BLE output SHALL be the LUT output combinationally.
REQ-018 With ff_en=1, the BLE output SHALL be a flip-flop on clk that captures the LUT output with 1-cycle latency in run mode.
REQ-019 While prog_en=1, every BLE flip-flop SHALL load its current ff_init bit on each edge.
REQ-020 While prog_en=1, clb_O SHALL be forced to all zeros.
REQ-021 SHALL maintain bit counter cfg_cnt of width clog2(CFG_BITS+1); it SHALL increment on each prog_en=1 edge and saturate at CFG_BITS.
REQ-022 cfg_done SHALL equal (cfg_cnt == CFG_BITS) && !prog_en.
REQ-023 A new programming burst SHALL NOT clear cfg_cnt; only reset clears it.
REQ-024 Combinational loops created by feedback through a bypassed BLE are the bitstream author's responsibility and need no detection.

Reset
REQ-025 reset=1 SHALL asynchronously clear cfg, all BLE flip-flops and cfg_cnt to 0.
REQ-026 During reset, clb_O=0, ccff_tail=0 and cfg_done=0.
REQ-027 Reset asserted mid-programming SHALL discard all partial configuration; loading SHALL restart from count 0 after release.
REQ-028 The first edge after reset release SHALL be a normal functional edge.

Verification (defaults N_IN=12, N_BLE=4, K=4)
REQ-029 Chain pass-through:
- Stimulus: reset, then prog_en=1 and a random 300-bit ccff_head stream.
- Response: ccff_tail equals ccff_head delayed exactly 136 cycles.
- Response: clb_O=0 throughout.
REQ-030 Done count:
- Stimulus: 135 programming cycles, then prog_en=0.
- Response: cfg_done=0.
- Stimulus: one more programming cycle, then prog_en=0.
- Response: cfg_done=1.
- Stimulus: 10 further programming cycles.
- Response: cfg_done stays 1 after prog_en falls.
REQ-031 Combinational AND:
- Stimulus: load BLE0 with LUT=0x8000, sel=(0,1,0,0), ff_en=0.
- Response: clb_O[0]=clb_I[0]&clb_I[1] in the same cycle, for all 4 input combinations.
REQ-032 Registered feedback toggle:
- Stimulus: load BLE1 with LUT=0x5555, sel0=13, ff_en=1, ff_init=1.
- Response: after prog_en falls, clb_O[1] reads 1, 0, 1, 0, ... on successive edges.
REQ-033 Init value:
- Stimulus: ff_en=1, ff_init=1, LUT=0x0000.
- Response: clb_O[0]=1 in the first run cycle and 0 after the first run edge.
REQ-034 Reset mid-load:
- Stimulus: assert reset after 70 programming bits.
- Response: cfg=0, cfg_cnt=0, cfg_done=0 and clb_O=0 immediately, without waiting for a clk edge.
- Stimulus: a full 136-bit reload.
- Response: cfg_done=1.

Source files
------------

// File: rtl/grid_clb_param.sv
// Parameterised logic tile: a serial configuration chain programs N_BLE K-input LUT/FF
// elements whose inputs are chosen from the tile inputs or from the tile's own outputs.
module grid_clb_param #(
    parameter int unsigned N_IN  = 12,
    parameter int unsigned N_BLE = 4,
    parameter int unsigned K     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             prog_en,
    input  logic             ccff_head,
    input  logic [N_IN-1:0]  clb_I,
    output logic [N_BLE-1:0] clb_O,
    output logic             ccff_tail,
    output logic             cfg_done
);

    localparam int unsigned SEL_W    = $clog2(N_IN + N_BLE);
    localparam int unsigned LUT_SZ   = 2 ** K;
    localparam int unsigned BLE_BITS = LUT_SZ + K * SEL_W + 2;
    localparam int unsigned CFG_BITS = N_BLE * BLE_BITS;
    localparam int unsigned CNT_W    = $clog2(CFG_BITS + 1);
    localparam int unsigned EN_OFF   = LUT_SZ + K * SEL_W;
    localparam int unsigned INIT_OFF = EN_OFF + 1;

    logic [CFG_BITS-1:0]     cfg_q, cfg_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [N_BLE-1:0]        ff_q, ff_d;
    logic [N_BLE-1:0]        lut_out;
    logic [N_BLE-1:0]        ble_out;
    logic [N_BLE-1:0][K-1:0] ble_in;

    // Out-of-range selects fall back to clb_I[0].
    function automatic logic pick(input logic [SEL_W-1:0] sel, input logic [N_IN-1:0] ins,
                                  input logic [N_BLE-1:0] fb);
        logic v;
        v = ins[0];
        for (int unsigned s = 0; s < N_IN; s++) begin
            if (sel == SEL_W'(s)) v = ins[s];
        end
        for (int unsigned f = 0; f < N_BLE; f++) begin
            if (sel == SEL_W'(N_IN + f)) v = fb[f];
        end
        return v;
    endfunction

    function automatic logic lut_lookup(input logic [LUT_SZ-1:0] tt, input logic [K-1:0] idx);
        return tt[idx];
    endfunction

    always_comb begin
        ble_in = '0;
        for (int unsigned b = 0; b < N_BLE; b++) begin
            for (int unsigned j = 0; j < K; j++) begin
                ble_in[b][j] = pick(cfg_q[b*BLE_BITS + LUT_SZ + j*SEL_W +: SEL_W], clb_I, clb_O);
            end
        end
    end

    always_comb begin
        lut_out = '0;
        ble_out = '0;
        for (int unsigned b = 0; b < N_BLE; b++) begin
            lut_out[b] = lut_lookup(cfg_q[b*BLE_BITS +: LUT_SZ], ble_in[b]);
            ble_out[b] = cfg_q[b*BLE_BITS + EN_OFF] ? ff_q[b] : lut_out[b];
        end
    end

    assign clb_O     = prog_en ? '0 : ble_out;
    assign ccff_tail = cfg_q[CFG_BITS-1];
    assign cfg_done  = (cnt_q == CNT_W'(CFG_BITS)) && !prog_en;

    // Flops preload ff_init as it stands after this edge's shift, so the last programming
    // edge leaves every registered BLE holding the init value of the complete bitstream.
    always_comb begin
        cfg_d = cfg_q;
        cnt_d = cnt_q;
        ff_d  = lut_out;
        if (prog_en) begin
            cfg_d = {cfg_q[CFG_BITS-2:0], ccff_head};
            if (cnt_q != CNT_W'(CFG_BITS)) cnt_d = cnt_q + 1'b1;
            for (int unsigned b = 0; b < N_BLE; b++) begin
                ff_d[b] = cfg_d[b*BLE_BITS + INIT_OFF];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q <= '0;
            cnt_q <= '0;
            ff_q  <= '0;
        end else begin
            cfg_q <= cfg_d;
            cnt_q <= cnt_d;
            ff_q  <= ff_d;
        end
    end

endmodule

// File: tb/tb_grid_clb_param.sv
// Self-checking bench for grid_clb_param: directed bitstreams plus constrained-random
// configurations, compared every cycle against a bitstream-level model of the tile.
module tb_grid_clb_param;

    localparam int NI = 12, NB = 4, SW = 4, LS = 16, BB = 34, CB = 136;
    localparam int EN_OFF = 32, INIT_OFF = 33;

    logic          clk = 1'b0, reset = 1'b0, prog_en = 1'b0, ccff_head = 1'b0;
    logic [NI-1:0] clb_I = '0;
    logic [NB-1:0] clb_O;
    logic          ccff_tail, cfg_done;

    grid_clb_param #(.N_IN(12), .N_BLE(4), .K(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .prog_en   (prog_en),
        .ccff_head (ccff_head),
        .clb_I     (clb_I),
        .clb_O     (clb_O),
        .ccff_tail (ccff_tail),
        .cfg_done  (cfg_done)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: history of bits shifted in since reset; config bit i is the i-th most recent.
    bit          m_hist[$];
    int          m_loaded = 0;
    bit [NB-1:0] m_ff = '0, m_out = '0, m_lut = '0;

    function automatic bit cfgbit(input int i);
        if (i < m_hist.size()) return m_hist[m_hist.size()-1-i];
        return 1'b0;
    endfunction

    function automatic int field(input int b, input int off, input int w);
        int v = 0;
        for (int k = 0; k < w; k++) v |= int'(cfgbit(b*BB + off + k)) << k;
        return v;
    endfunction

    // Repeated passes settle chains of bypassed BLEs feeding one another.
    function automatic void model_eval();
        m_out = '0;
        m_lut = '0;
        for (int pass = 0; pass <= NB; pass++) begin
            for (int b = 0; b < NB; b++) begin
                int idx = 0;
                for (int j = 0; j < 4; j++) begin
                    int s = field(b, LS + j*SW, SW);
                    bit v;
                    if (s < NI) v = clb_I[s];
                    else if (s < NI + NB) v = m_out[s-NI];
                    else v = clb_I[0];
                    idx |= int'(v) << j;
                end
                m_lut[b] = cfgbit(b*BB + idx);
                m_out[b] = prog_en ? 1'b0 : (field(b, EN_OFF, 1) != 0 ? m_ff[b] : m_lut[b]);
            end
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hist.delete();
            m_loaded = 0;
            m_ff = '0;
        end else if (prog_en) begin
            m_hist.push_back(ccff_head);
            if (m_hist.size() > CB) void'(m_hist.pop_front());
            m_loaded++;
            for (int b = 0; b < NB; b++) m_ff[b] = cfgbit(b*BB + INIT_OFF);
        end else begin
            model_eval();
            for (int b = 0; b < NB; b++) if (field(b, EN_OFF, 1) != 0) m_ff[b] = m_lut[b];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            model_eval();
            chk("cyc_clb_O", 32'(clb_O), 32'(m_out));
            chk("cyc_ccff_tail", 32'(ccff_tail), 32'(cfgbit(CB-1)));
            chk("cyc_cfg_done", 32'(cfg_done), 32'(m_loaded >= CB && !prog_en));
        end
    end

    bit [CB-1:0] img;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_ble(input int b, input int lut, input int s0, input int s1, input int s2,
                           input int s3, input bit en, input bit init);
        int s[4];
        s = '{s0, s1, s2, s3};
        for (int i = 0; i < LS; i++) img[b*BB + i] = bit'((lut >> i) & 1);
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < SW; k++) img[b*BB + LS + j*SW + k] = bit'((s[j] >> k) & 1);
        img[b*BB + EN_OFF]   = en;
        img[b*BB + INIT_OFF] = init;
    endtask

    // Registered BLEs may read anything; a bypassed BLE only reads lower-index bypassed ones.
    task automatic gen_img();
        bit [NB-1:0] en;
        for (int b = 0; b < NB; b++) en[b] = bit'($urandom % 2);
        img = '0;
        for (int b = 0; b < NB; b++) begin
            int s[4];
            for (int j = 0; j < 4; j++) begin
                s[j] = int'($urandom % 16);
                if (s[j] >= NI && !en[b] && !en[s[j]-NI] && (s[j] - NI) >= b)
                    s[j] = int'($urandom % NI);
            end
            put_ble(b, int'($urandom % 65536), s[0], s[1], s[2], s[3], en[b], bit'($urandom % 2));
        end
    endtask

    // MSB first; with split_check, pause before the final bit to confirm the count boundary.
    task automatic load_img(input bit split_check);
        prog_en = 1'b1;
        for (int i = CB - 1; i >= 0; i--) begin
            if (split_check && i == 0) begin
                prog_en = 1'b0;
                #1;
                chk("load_done_at_135", 32'(cfg_done), 32'd0);
                prog_en = 1'b1;
            end
            ccff_head = img[i];
            tick();
        end
        prog_en   = 1'b0;
        ccff_head = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        chk("rst_clb_O", 32'(clb_O), 32'd0);
        chk("rst_ccff_tail", 32'(ccff_tail), 32'd0);
        chk("rst_cfg_done", 32'(cfg_done), 32'd0);
        prog_en   = 1'b0;
        ccff_head = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bit s[300];
        #1;
        do_reset();
        chk_en = 1'b1;

        // Chain pass-through: tail is the head delayed by exactly 136 edges.
        prog_en = 1'b1;
        #1;
        for (int i = 0; i < 300; i++) begin
            chk("chain_tail", 32'(ccff_tail), (i >= CB) ? 32'(s[i-CB]) : 32'd0);
            chk("chain_clb_O", 32'(clb_O), 32'd0);
            s[i] = bit'($urandom % 2);
            ccff_head = s[i];
            tick();
        end
        do_reset();

        // Done count boundary and saturation.
        prog_en = 1'b1;
        repeat (135) tick();
        prog_en = 1'b0;
        #1;
        chk("done_after_135", 32'(cfg_done), 32'd0);
        prog_en = 1'b1;
        tick();
        prog_en = 1'b0;
        #1;
        chk("done_after_136", 32'(cfg_done), 32'd1);
        prog_en = 1'b1;
        repeat (10) tick();
        chk("done_low_in_prog", 32'(cfg_done), 32'd0);
        prog_en = 1'b0;
        #1;
        chk("done_after_146", 32'(cfg_done), 32'd1);

        // Combinational AND of clb_I[0] and clb_I[1].
        do_reset();
        img = '0;
        put_ble(0, 'h8000, 0, 1, 0, 0, 1'b0, 1'b0);
        load_img(1'b0);
        for (int c = 0; c < 4; c++) begin
            clb_I = NI'($urandom);
            clb_I[0] = c[0];
            clb_I[1] = c[1];
            #1;
            chk("comb_and", 32'(clb_O[0]), 32'(c[0] & c[1]));
            tick();
        end

        // Registered inverter fed back from its own output toggles from ff_init.
        do_reset();
        img = '0;
        put_ble(1, 'h5555, 13, 0, 0, 0, 1'b1, 1'b1);
        load_img(1'b0);
        for (int k = 0; k < 6; k++) begin
            chk("toggle", 32'(clb_O[1]), (k % 2 == 0) ? 32'd1 : 32'd0);
            tick();
        end

        // Init value visible in the first run cycle, then replaced by the LUT.
        img = '0;
        put_ble(0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
        load_img(1'b0);
        chk("init_first", 32'(clb_O[0]), 32'd1);
        tick();
        chk("init_after_edge", 32'(clb_O[0]), 32'd0);

        // Reset mid-load is asynchronous and discards the partial configuration.
        do_reset();
        prog_en   = 1'b1;
        ccff_head = 1'b1;
        repeat (70) tick();
        prog_en   = 1'b0;
        ccff_head = 1'b0;
        #1;
        chk("partial_ble1", 32'(clb_O[1]), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_clb_O", 32'(clb_O), 32'd0);
        chk("async_cfg_done", 32'(cfg_done), 32'd0);
        chk("async_tail", 32'(ccff_tail), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("cleared_clb_O", 32'(clb_O), 32'd0);
        gen_img();
        load_img(1'b1);
        chk("reload_done", 32'(cfg_done), 32'd1);

        // Constrained-random configurations exercised with random tile inputs.
        for (int r = 0; r < 10; r++) begin
            if (r % 4 == 3) do_reset();
            gen_img();
            load_img(1'b0);
            repeat (25) begin
                clb_I = NI'($urandom);
                tick();
            end
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
